// File: rtl/max7219_refresh_ctrl.sv
// Config/refresh sequencer in front of max7219_settings, with per-transaction watchdog.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits during refresh.
module max7219_refresh_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_refresh,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic                    i_config_req,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic                    o_stb,
  output logic                    o_write_config,
  output logic [2:0]              o_digit,
  output logic [7:0]              o_segment,
  input  logic                    i_busy,
  input  logic                    i_ack
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic           cfg_q, cfg_d;
  logic           ref_q, ref_d;
  logic           job_cfg_q, job_cfg_d;
  logic [DW-1:0]  snap_q, snap_d;
  logic [2:0]     idx_q, idx_d;
  logic [RW-1:0]  rty_q, rty_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic           stb_q, stb_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic [3:0]     cur_bcd;
  logic           timeout;

  function automatic logic [DW-1:0] load_snap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // Walk down from the top digit; digit 0 always shows.
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (lead && d[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  always_comb begin
    cur_bcd = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) cur_bcd = snap_q[4*i +: 4];
    end
  end

  assign timeout = (wd_q == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q | i_config_req;
    ref_d     = ref_q | i_refresh;
    job_cfg_d = job_cfg_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    rty_d     = rty_q;
    wd_d      = wd_q;
    stb_d     = stb_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_q | i_config_req) begin
          cfg_d     = 1'b0;
          job_cfg_d = 1'b1;
          idx_d     = 3'd0;
          rty_d     = '0;
          wd_d      = '0;
          stb_d     = 1'b1;
          state_d   = S_ISSUE;
        end else if (ref_q | i_refresh) begin
          ref_d     = 1'b0;
          job_cfg_d = 1'b0;
          snap_d    = load_snap(i_digits);
          idx_d     = 3'd0;
          rty_d     = '0;
          wd_d      = '0;
          stb_d     = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (state_q == S_ISSUE && i_busy) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end else if (state_q == S_WAIT && !i_busy && i_ack) begin
          state_d = S_NEXT;
        end else if (timeout) begin
          stb_d = 1'b0;
          if (rty_q < RW'(MAX_RETRIES)) begin
            rty_d   = rty_q + 1'b1;
            state_d = S_GAP;
          end else begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end
        end
      end
      S_GAP: begin
        wd_d    = '0;
        stb_d   = 1'b1;
        state_d = S_ISSUE;
      end
      S_NEXT: begin
        if (!job_cfg_q && idx_q != 3'(NUM_DIGITS - 1)) begin
          idx_d   = idx_q + 3'd1;
          rty_d   = '0;
          wd_d    = '0;
          stb_d   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) | cfg_d | ref_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cfg_q     <= 1'b1;
      ref_q     <= 1'b0;
      job_cfg_q <= 1'b0;
      snap_q    <= '0;
      idx_q     <= 3'd0;
      rty_q     <= '0;
      wd_q      <= '0;
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      ref_q     <= ref_d;
      job_cfg_q <= job_cfg_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      rty_q     <= rty_d;
      wd_q      <= wd_d;
      stb_q     <= stb_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = err_q;
  assign o_stb          = stb_q;
  assign o_write_config = job_cfg_q;
  assign o_digit        = idx_q;
  assign o_segment      = job_cfg_q ? 8'h00 : {4'h0, cur_bcd};

endmodule

// File: tb/tb_max7219_refresh_ctrl.sv
// Bench for max7219_refresh_ctrl: stub downstream, transaction log vs reference model.
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_max7219_refresh_ctrl;

  localparam int ND = 6;
  localparam int TO = 255;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refresh = 1'b0;
  logic        cfg_req = 1'b0;
  logic        busy_i = 1'b0;
  logic        ack_i = 1'b0;
  logic [23:0] digits = 24'h0;
  logic        busy_o, done_o, err_o, stb_o, wc_o;
  logic [2:0]  dig_o;
  logic [7:0]  seg_o;

  always #5 clk = ~clk;

  max7219_refresh_ctrl #(
    .NUM_DIGITS(ND), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_refresh(refresh),
    .i_digits(digits), .i_config_req(cfg_req),
    .o_busy(busy_o), .o_done(done_o), .o_error(err_o),
    .o_stb(stb_o), .o_write_config(wc_o),
    .o_digit(dig_o), .o_segment(seg_o),
    .i_busy(busy_i), .i_ack(ack_i)
  );

  int total = 0;
  int bad = 0;
  logic [11:0] got[$];
  logic [11:0] exp_q[$];
  int lens[$];
  int done_cnt = 0;
  int att0 = 0;
  int cur_len = 0;
  logic prev_stb = 1'b0;
  bit respond = 1'b1;
  int dly = 0;
  int bcnt = 0;
  int phase = 0;
  int dmax = 3;
  int bmax = 5;

  typedef struct {
    logic [23:0] d;
    logic [23:0] late;
    bit          cfg_same;
    bit          cfg_mid;
    int          ntx;
    int          ndone;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (done_o) done_cnt++;
    if (stb_o) cur_len++;
    if (stb_o && !prev_stb && dig_o == 3'd0) att0++;
    if (!stb_o && prev_stb) begin
      lens.push_back(cur_len);
      cur_len = 0;
    end
    prev_stb = stb_o;
    ack_i = 1'b0;
    if (phase == 0) begin
      if (stb_o && respond) begin
        if (dly == 0) begin
          busy_i = 1'b1;
          got.push_back({wc_o, dig_o, seg_o});
          bcnt = $urandom_range(1, bmax);
          phase = 1;
        end else begin
          dly--;
        end
      end
    end else begin
      bcnt--;
      if (bcnt <= 0) begin
        busy_i = 1'b0;
        ack_i = 1'b1;
        phase = 0;
        dly = $urandom_range(0, dmax);
      end
    end
  endtask

  task automatic fire(input bit r, input bit c);
    refresh = r;
    cfg_req = c;
    cyc();
    refresh = 1'b0;
    cfg_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy_o && k < budget) begin
      cyc();
      k++;
    end
    chk({nm, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  function automatic void model_cfg();
    exp_q.push_back(12'h800);
  endfunction

  // Expected digit writes: blanking hides everything above the highest non-zero digit.
  function automatic void model_refresh(input logic [23:0] d);
    int v[ND];
    int top = 0;
    int s;
    for (int n = 0; n < ND; n++) begin
      v[n] = int'(d[4*n +: 4]);
      if (v[n] != 0) top = n;
    end
    for (int n = 0; n < ND; n++) begin
      s = v[n];
`ifdef LEADING_ZERO_BLANK_EN
      if (n > top) s = 15;
`endif
      exp_q.push_back({1'b0, 3'(n), 4'h0, 4'(s)});
    end
  endfunction

  task automatic cmp_q(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_tx%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    int k;
    logic [23:0] rd;
    bit cs;

    tbl[0] = '{24'h123456, 24'h123456, 1'b0, 1'b0, 6, 1};
    tbl[1] = '{24'h123456, 24'h999999, 1'b0, 1'b0, 6, 1};
    tbl[2] = '{24'h001205, 24'h001205, 1'b1, 1'b0, 7, 2};
    tbl[3] = '{24'h000000, 24'h000000, 1'b0, 1'b1, 7, 2};
    tbl[4] = '{24'h900000, 24'h987654, 1'b1, 1'b0, 7, 2};

    #1 rst = 1'b1;
    repeat (3) cyc();
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_wc", 32'(wc_o), 32'd0);
    chk("rst_digit", 32'(dig_o), 32'd0);
    chk("rst_seg", 32'(seg_o), 32'd0);

    rst = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      cyc();
      if (stb_o && wc_o) seen = 1'b1;
    end
    chk("boot_cfg_stb", 32'(seen), 32'd1);
    wait_idle("boot", 500);
    chk("boot_done", 32'(done_cnt), 32'd1);
    model_cfg();
    cmp_q("boot");

    foreach (tbl[t]) begin
      done_cnt = 0;
      digits = tbl[t].d;
      fire(1'b1, tbl[t].cfg_same);
      digits = tbl[t].late;
      if (tbl[t].cfg_mid) begin
        repeat (5) cyc();
        fire(1'b0, 1'b1);
      end
      if (tbl[t].cfg_same) model_cfg();
      model_refresh(tbl[t].cfg_same ? tbl[t].late : tbl[t].d);
      if (tbl[t].cfg_mid) model_cfg();
      wait_idle($sformatf("vec%0d", t), 2000);
      chk($sformatf("vec%0d_ntx", t), 32'(got.size()), 32'(tbl[t].ntx));
      chk($sformatf("vec%0d_done", t), 32'(done_cnt), 32'(tbl[t].ndone));
      cmp_q($sformatf("vec%0d", t));
    end

    done_cnt = 0;
    digits = 24'h314159;
    fire(1'b1, 1'b0);
    repeat (3) cyc();
    fire(1'b1, 1'b0);
    repeat (4) cyc();
    fire(1'b1, 1'b0);
    model_refresh(24'h314159);
    model_refresh(24'h314159);
    wait_idle("merge", 3000);
    chk("merge_done", 32'(done_cnt), 32'd2);
    cmp_q("merge");

    for (int it = 0; it < 12; it++) begin
      rd = '0;
      for (int n = 0; n < ND; n++) begin
        if ($urandom_range(0, 2) != 0) rd[4*n +: 4] = 4'($urandom_range(0, 9));
      end
      dmax = $urandom_range(0, 4);
      bmax = $urandom_range(1, 8);
      cs = ($urandom_range(0, 3) == 0);
      done_cnt = 0;
      digits = rd;
      fire(1'b1, cs);
      if (cs) model_cfg();
      model_refresh(rd);
      wait_idle($sformatf("rnd%0d", it), 2000);
      chk($sformatf("rnd%0d_done", it), 32'(done_cnt), cs ? 32'd2 : 32'd1);
      cmp_q($sformatf("rnd%0d", it));
    end

    respond = 1'b0;
    att0 = 0;
    lens.delete();
    cur_len = 0;
    done_cnt = 0;
    digits = 24'h123456;
    fire(1'b1, 1'b0);
    k = 0;
    while (dig_o == 3'd0 && k < 1500) begin
      cyc();
      k++;
    end
    chk("to_advance", 32'(dig_o), 32'd1);
    chk("to_attempts", 32'(att0), 32'd3);
    chk("to_pulses", 32'(lens.size()), 32'd3);
    for (int i = 0; i < lens.size() && i < 3; i++) begin
      chk($sformatf("to_len%0d", i), 32'(lens[i]), 32'(TO));
    end
    chk("to_err", 32'(err_o), 32'd1);
    respond = 1'b1;
    model_refresh(24'h123456);
    void'(exp_q.pop_front());
    wait_idle("to", 2000);
    chk("to_done", 32'(done_cnt), 32'd1);
    chk("to_err_sticky", 32'(err_o), 32'd1);
    cmp_q("to");

    digits = 24'h123456;
    fire(1'b1, 1'b0);
    k = 0;
    while (!(dig_o == 3'd2 && stb_o) && k < 200) begin
      cyc();
      k++;
    end
    chk("ar_reach", 32'(dig_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_stb", 32'(stb_o), 32'd0);
    chk("ar_err", 32'(err_o), 32'd0);
    busy_i = 1'b0;
    ack_i = 1'b0;
    phase = 0;
    dly = 0;
    got.delete();
    exp_q.delete();
    @(negedge clk);
    prev_stb = stb_o;
    rst = 1'b0;
    done_cnt = 0;
    cyc();
    model_cfg();
    wait_idle("ar", 500);
    chk("ar_done", 32'(done_cnt), 32'd1);
    cmp_q("ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max7219_refresh_ctrl.md
Name: max7219_refresh_ctrl

Overview:
- Sequencer in front of max7219_settings, which in turn feeds the max7219 serial driver.
- After reset it issues one configuration write. From then on, each refresh request causes it to write a latched snapshot of NUM_DIGITS BCD digits, one digit per transaction.
- Configuration-change requests and refresh requests are arbitrated, and every transaction is guarded by a watchdog that retries on timeout.
- Sits between the clock/time datapath and max7219_settings.

Parameters:
- NUM_DIGITS, 6: digits written per refresh (1..8); sets width of i_digits.
- TIMEOUT_CYCLES, 255: cycles allowed per transaction before abort/retry.
- MAX_RETRIES, 2: retries per transaction before flagging an error and skipping it.

Ports:
- i_clk  in  1  system clock (~50 MHz).
- i_reset  in  1  asynchronous reset, active-high.
- i_refresh  in  1  pulse; request a display refresh.
- i_digits  in  4*NUM_DIGITS  packed BCD; digit n at [4n+3:4n].
- i_config_req  in  1  pulse; settings changed, rewrite configuration.
- o_busy  out  1  high while any transaction is pending or in flight.
- o_done  out  1  one-cycle pulse when a refresh or config sequence completes.
- o_error  out  1  sticky; set when a transaction exhausts its retries; cleared by reset.
- o_stb  out  1  to max7219_settings i_stb.
- o_write_config  out  1  to max7219_settings i_write_config.
- o_digit  out  3  to max7219_settings i_digit.
- o_segment  out  8  to max7219_settings i_segment; {4'h0, bcd}.
- i_busy  in  1  from max7219_settings o_busy.
- i_ack  in  1  from max7219_settings o_ack.

Behaviour:
- Reset values: all outputs 0.
  - The config-pending flag resets to 1, so configuration is always written first.
  - The refresh-pending flag, snapshot register, digit index, retry count and watchdog all reset to 0.
- Asynchronous reset mid-transaction: state returns to IDLE immediately and o_stb drops. No recovery of the partial sequence; the config write re-runs.
- Pending flags:
  - i_refresh sets refresh_pend.
  - i_config_req sets cfg_pend.
  - Pulses arriving while busy are held in the flags, not lost; multiple pulses merge.
  - i_digits is sampled only at sequence start (IDLE->ISSUE of digit 0).
- States:
  - IDLE:
    - If cfg_pend: clear it, load config job, go to ISSUE.
    - Else if refresh_pend: clear it, latch i_digits, set index 0, go to ISSUE.
    - Config has priority when both are pending in the same cycle.
  - ISSUE:
    - Hold o_stb=1 with o_write_config, o_digit, o_segment stable.
    - Leave when i_busy=1: drop o_stb next cycle and go to WAIT.
  - WAIT:
    - Outputs stay stable.
    - When i_busy=0 and i_ack=1: transaction complete, go to NEXT.
  - NEXT:
    - Config job: pulse o_done, go to IDLE.
    - Digit job with index < NUM_DIGITS-1: increment index, reset retry count, go to ISSUE.
    - Digit job with index = NUM_DIGITS-1: pulse o_done, go to IDLE.
- Watchdog:
  - Counts cycles spent in ISSUE+WAIT; cleared on entry to ISSUE.
  - When it reaches TIMEOUT_CYCLES: drop o_stb.
    - If retry count < MAX_RETRIES: increment it, go to ISSUE after 1 idle cycle.
    - Else: set o_error and treat as complete (go to NEXT).
- A config request arriving mid-refresh is serviced after the current refresh finishes; a refresh is never preempted.
- o_busy = (state != IDLE) | cfg_pend | refresh_pend.
- Latency:
  - IDLE->o_stb: 1 cycle.
  - Back-to-back digits: ISSUE is re-entered 1 cycle after the ack is seen.
- o_digit = index[2:0]; the downstream block adds 1 for the register address.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - During a refresh, digits from the most significant (index NUM_DIGITS-1) downward whose latched BCD is 0 are sent as 4'hF (code-B blank), up to the first non-zero digit.
  - Digit 0 is never blanked.
  - Example: snapshot 00_12_05 displays "  1205".
- Undefined: digits are sent exactly as latched.

Test Plan:
- Reset release -> first transaction has o_write_config=1 and o_stb=1 within 2 cycles; o_done pulses once after ack; o_busy returns to 0.
- i_refresh with i_digits=24'h123456 -> 6 transactions in order: (digit 0, seg 8'h06), (1, 8'h05), (2, 8'h04), (3, 8'h03), (4, 8'h02), (5, 8'h01); exactly one o_done.
- i_digits changed to 24'h999999 one cycle after i_refresh -> all writes still carry the 24'h123456 snapshot.
- i_config_req and i_refresh in the same IDLE cycle -> config write first, then the 6 digits; 2 o_done pulses.
- Downstream stub never asserts i_busy -> exactly 3 o_stb attempts, each TIMEOUT_CYCLES long; o_error=1; sequence advances to the next digit.
- Build with LEADING_ZERO_BLANK_EN and refresh with 24'h001205 -> digits 5 and 4 carry seg 8'h0F; digits 3..0 carry 8'h01, 8'h02, 8'h00, 8'h05.
